// File: rtl/interlaken_pkg.sv
// Shared constants, lane state type and the 64-bit descramble helper
// for the Interlaken receive descrambler.
package interlaken_pkg;

    localparam logic [63:0] SYNC_WORD_DEFAULT = 64'h78f678f678f678f6;

    // Taps of x^58 + x^39 + 1, as indices into the 58-bit state
    localparam int TAP_A = 38;
    localparam int TAP_B = 57;

    // 67b framing header codes
    localparam logic [1:0] HDR_CTRL = 2'b10;
    localparam logic [1:0] HDR_DATA = 2'b01;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } lane_state_t;

    typedef struct packed {
        logic [63:0] data;
        logic [57:0] state;
    } descr_t;

    // Self-synchronous descramble of one word, LSB first; returns the
    // plaintext and the state after all 64 bits have been shifted in.
    function automatic descr_t descramble64(input logic [63:0] din,
                                            input logic [57:0] s_in);
        descr_t      r;
        logic [57:0] s;
        r = '0;
        s = s_in;
        for (int i = 0; i < 64; i++) begin
            r.data[i] = din[i] ^ s[TAP_A] ^ s[TAP_B];
            s = {s[56:0], din[i]};
        end
        r.state = s;
        return r;
    endfunction

endpackage

// File: rtl/interlaken_descrambler_lane.sv
// Single-lane Interlaken engine: metaframe hunt/verify/lock, scrambler
// state tracking and payload descramble, all outputs registered.
//
// Stream contract: one word per clock is consumed unconditionally; there
// is no valid/ready handshake. ctrl_out marks sync/state words seen while
// locked, valid_out marks descrambled payload words; both are aligned
// with data_out, one cycle after data_in.
module interlaken_descrambler_lane
    import interlaken_pkg::*;
#(
    parameter logic [63:0] SYNC_WORD      = SYNC_WORD_DEFAULT,
    parameter int          META_FRAME_LEN = 16,
    parameter int          SYNC_GOOD      = 4,
    parameter int          SYNC_BAD       = 4,
    parameter int          MISMATCH_MAX   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        passthrough,
    input  logic [63:0] data_in,
    input  logic [1:0]  header_in,
    output logic [63:0] data_out,
    output logic [1:0]  header_out,
    output logic        ctrl_out,
    output logic        valid_out,
    output logic [7:0]  err_cnt,
    output lane_state_t state
);

    localparam int            PW       = (META_FRAME_LEN > 2) ? $clog2(META_FRAME_LEN) : 1;
    localparam logic [PW-1:0] POS_LAST = PW'(META_FRAME_LEN - 1);
    localparam logic [PW-1:0] POS_ST   = PW'(1);
    localparam logic [15:0]   GOOD_MAX = 16'(SYNC_GOOD);
    localparam logic [15:0]   BAD_MAX  = 16'(SYNC_BAD);
    localparam logic [15:0]   MM_MAX   = 16'(MISMATCH_MAX);

    logic [PW-1:0] pos;
    logic [PW-1:0] pos_next;
    logic [15:0]   good_ctr;
    logic [15:0]   bad_ctr;
    logic [15:0]   mm_ctr;
    logic [57:0]   scr;
    logic          first_state;
    logic          sync_ok;
    logic          to_hunt;
    logic [7:0]    err_inc;
    descr_t        descr;

    // Word classification, unlock decisions and the descramble of this word
    always_comb begin
        sync_ok  = (data_in == SYNC_WORD) && (header_in == HDR_CTRL);
        pos_next = (pos == POS_LAST) ? '0 : pos + PW'(1);
        err_inc  = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
        descr    = descramble64(data_in, scr);
        to_hunt  = passthrough;
        if ((state == ST_VERIFY) && (pos == '0) && !sync_ok)
            to_hunt = 1'b1;
        if ((state == ST_LOCKED) && (pos == '0) && !sync_ok &&
            ((bad_ctr + 16'd1) >= BAD_MAX))
            to_hunt = 1'b1;
        if ((state == ST_LOCKED) && (pos == POS_ST) && !first_state &&
            (scr != data_in[57:0]) && ((mm_ctr + 16'd1) >= MM_MAX))
            to_hunt = 1'b1;
    end

    // Lane FSM, counters, scrambler state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_HUNT;
            pos         <= '0;
            good_ctr    <= '0;
            bad_ctr     <= '0;
            mm_ctr      <= '0;
            scr         <= '1;
            first_state <= 1'b1;
            err_cnt     <= '0;
            data_out    <= '0;
            header_out  <= '0;
            ctrl_out    <= 1'b0;
            valid_out   <= 1'b0;
        end else begin
            data_out   <= data_in;
            header_out <= header_in;
            ctrl_out   <= 1'b0;
            valid_out  <= 1'b0;
            if (!passthrough) begin
                case (state)
                    ST_HUNT: begin
                        if (sync_ok) begin
                            pos <= POS_ST;
                            if (GOOD_MAX <= 16'd1) begin
                                state       <= ST_LOCKED;
                                good_ctr    <= '0;
                                bad_ctr     <= '0;
                                mm_ctr      <= '0;
                                first_state <= 1'b1;
                            end else begin
                                good_ctr <= 16'd1;
                                state    <= ST_VERIFY;
                            end
                        end
                    end
                    ST_VERIFY: begin
                        pos <= pos_next;
                        if ((pos == '0) && sync_ok) begin
                            good_ctr <= good_ctr + 16'd1;
                            if ((good_ctr + 16'd1) >= GOOD_MAX) begin
                                state       <= ST_LOCKED;
                                bad_ctr     <= '0;
                                mm_ctr      <= '0;
                                first_state <= 1'b1;
                            end
                        end
                    end
                    ST_LOCKED: begin
                        pos <= pos_next;
                        if (pos == '0) begin
                            ctrl_out <= 1'b1;
                            if (sync_ok) begin
                                bad_ctr <= '0;
                            end else begin
                                bad_ctr <= bad_ctr + 16'd1;
                                err_cnt <= err_inc;
                            end
                        end else if (pos == POS_ST) begin
                            ctrl_out <= 1'b1;
                            if (first_state) begin
                                scr         <= data_in[57:0];
                                first_state <= 1'b0;
                            end else if (scr == data_in[57:0]) begin
                                mm_ctr <= '0;
                            end else begin
                                scr     <= data_in[57:0];
                                mm_ctr  <= mm_ctr + 16'd1;
                                err_cnt <= err_inc;
                            end
                        end else begin
                            valid_out <= 1'b1;
                            data_out  <= descr.data;
                            scr       <= descr.state;
                        end
                    end
                    default: state <= ST_HUNT;
                endcase
            end
            // Any return to HUNT restarts alignment from scratch; the error
            // counter is deliberately left alone.
            if (to_hunt) begin
                state       <= ST_HUNT;
                pos         <= '0;
                good_ctr    <= '0;
                bad_ctr     <= '0;
                mm_ctr      <= '0;
                scr         <= '1;
                first_state <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/interlaken_mlane_descrambler.sv
// Multi-lane Interlaken receive descrambler: LANES independent lane
// engines on flat buses, lane n at bits [64n+63:64n].
module interlaken_mlane_descrambler
    import interlaken_pkg::*;
#(
    parameter int          LANES          = 4,
    parameter int          RX_DATA_WIDTH  = 64,
    parameter logic [63:0] SYNC_WORD      = SYNC_WORD_DEFAULT,
    parameter int          META_FRAME_LEN = 16,
    parameter int          SYNC_GOOD      = 4,
    parameter int          SYNC_BAD       = 4,
    parameter int          MISMATCH_MAX   = 3
) (
    input  logic                           USER_CLK,
    input  logic                           SYSTEM_RESET,
    input  logic                           PASSTHROUGH,
    input  logic [LANES*RX_DATA_WIDTH-1:0] SCRAMBLED_DATA_IN,
    input  logic [LANES*2-1:0]             HEADER_IN,
    output logic [LANES*RX_DATA_WIDTH-1:0] UNSCRAMBLED_DATA_OUT,
    output logic [LANES*2-1:0]             HEADER_OUT,
    output logic [LANES-1:0]               CTRL_OUT,
    output logic [LANES-1:0]               VALID_OUT,
    output logic [LANES-1:0]               LOCKED,
    output logic                           ALL_LOCKED,
    output logic [LANES*8-1:0]             ERR_CNT
);

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        lane_state_t lane_state;

        interlaken_descrambler_lane #(
            .SYNC_WORD      (SYNC_WORD),
            .META_FRAME_LEN (META_FRAME_LEN),
            .SYNC_GOOD      (SYNC_GOOD),
            .SYNC_BAD       (SYNC_BAD),
            .MISMATCH_MAX   (MISMATCH_MAX)
        ) u_lane (
            .clk         (USER_CLK),
            .rst         (SYSTEM_RESET),
            .passthrough (PASSTHROUGH),
            .data_in     (SCRAMBLED_DATA_IN[n*RX_DATA_WIDTH +: RX_DATA_WIDTH]),
            .header_in   (HEADER_IN[n*2 +: 2]),
            .data_out    (UNSCRAMBLED_DATA_OUT[n*RX_DATA_WIDTH +: RX_DATA_WIDTH]),
            .header_out  (HEADER_OUT[n*2 +: 2]),
            .ctrl_out    (CTRL_OUT[n]),
            .valid_out   (VALID_OUT[n]),
            .err_cnt     (ERR_CNT[n*8 +: 8]),
            .state       (lane_state)
        );

        // Lock status is a decode of the registered lane state
        assign LOCKED[n] = (lane_state == ST_LOCKED);
    end

    assign ALL_LOCKED = &LOCKED;

endmodule

// File: tb/tb_interlaken_mlane_descrambler.sv
// Directed bench for interlaken_mlane_descrambler with two lanes.
module tb_interlaken_mlane_descrambler;
    import interlaken_pkg::*;

    localparam int LANES = 2;
    localparam int MFL   = 16;
    localparam logic [63:0] PT_TAB [4] = '{64'h0123_4567_89ab_cdef,
                                           64'hffff_0000_ffff_0000,
                                           64'h0000_0000_0000_0000,
                                           64'hdead_beef_cafe_f00d};
    // State word with bit 0 flipped corrupts payload bits 38 and 57 once
    localparam logic [63:0] MM_FLIP = 64'h0200_0040_0000_0000;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   pt_mode;
    logic [LANES*64-1:0]    din;
    logic [LANES*2-1:0]     hin;
    logic [LANES*64-1:0]    dout;
    logic [LANES*2-1:0]     hout;
    logic [LANES-1:0]       ctrl;
    logic [LANES-1:0]       valid;
    logic [LANES-1:0]       locked;
    logic                   all_locked;
    logic [LANES*8-1:0]     err;

    int          n_total = 0;
    int          n_bad   = 0;
    int          mf_n    = 0;
    bit          chk_words = 1'b1;
    logic [57:0] tx_scr [LANES];
    logic [LANES-1:0] st_flip;
    logic [63:0] exp_q [$];

    interlaken_mlane_descrambler #(
        .LANES          (LANES),
        .RX_DATA_WIDTH  (64),
        .SYNC_WORD      (SYNC_WORD_DEFAULT),
        .META_FRAME_LEN (MFL),
        .SYNC_GOOD      (4),
        .SYNC_BAD       (4),
        .MISMATCH_MAX   (3)
    ) dut (
        .USER_CLK             (clk),
        .SYSTEM_RESET         (rst),
        .PASSTHROUGH          (pt_mode),
        .SCRAMBLED_DATA_IN    (din),
        .HEADER_IN            (hin),
        .UNSCRAMBLED_DATA_OUT (dout),
        .HEADER_OUT           (hout),
        .CTRL_OUT             (ctrl),
        .VALID_OUT            (valid),
        .LOCKED               (locked),
        .ALL_LOCKED           (all_locked),
        .ERR_CNT              (err)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Transmit-side scrambler: c = p ^ s38 ^ s57, state shifts in c
    task automatic scramble(input int l, input logic [63:0] p, output logic [63:0] c);
        logic [57:0] s;
        s = tx_scr[l];
        c = '0;
        for (int i = 0; i < 64; i++) begin
            c[i] = p[i] ^ s[38] ^ s[57];
            s = {s[56:0], c[i]};
        end
        tx_scr[l] = s;
    endtask

    // Drive one word per lane at position p; lk says which lanes should
    // treat it as locked. Checks the outputs one cycle later.
    task automatic send_word(input int p, input logic [LANES-1:0] bsync,
                             input logic [LANES-1:0] bhdr, input logic [LANES-1:0] bstate,
                             input logic [LANES-1:0] lk);
        logic [63:0] w [LANES];
        logic [1:0]  h [LANES];
        logic [63:0] c;
        logic [63:0] plain;
        logic [63:0] e;
        for (int l = 0; l < LANES; l++) begin
            if (p == 0) begin
                w[l] = bsync[l] ? ~SYNC_WORD_DEFAULT : SYNC_WORD_DEFAULT;
                h[l] = bhdr[l] ? HDR_DATA : HDR_CTRL;
                exp_q.push_back(w[l]);
            end else if (p == 1) begin
                w[l] = {6'b0, tx_scr[l] ^ (bstate[l] ? 58'h1 : 58'h0)};
                st_flip[l] = bstate[l];
                h[l] = HDR_CTRL;
                exp_q.push_back(w[l]);
            end else begin
                plain = PT_TAB[p % 4] ^ {32'(mf_n), 32'(p)};
                scramble(l, plain, c);
                w[l] = c;
                h[l] = HDR_DATA;
                if (!lk[l])                    exp_q.push_back(c);
                else if (p == 2 && st_flip[l]) exp_q.push_back(plain ^ MM_FLIP);
                else                           exp_q.push_back(plain);
            end
        end
        @(negedge clk);
        for (int l = 0; l < LANES; l++) begin
            din[l*64 +: 64] = w[l];
            hin[l*2 +: 2]   = h[l];
        end
        @(posedge clk);
        #1;
        for (int l = 0; l < LANES; l++) begin
            e = exp_q.pop_front();
            if (chk_words) begin
                check_eq($sformatf("l%0d.p%0d.data", l, p), dout[l*64 +: 64], e);
                check_eq($sformatf("l%0d.p%0d.hdr", l, p), 64'(hout[l*2 +: 2]), 64'(h[l]));
                check_eq($sformatf("l%0d.p%0d.ctrl", l, p), 64'(ctrl[l]), 64'(lk[l] && p < 2));
                check_eq($sformatf("l%0d.p%0d.valid", l, p), 64'(valid[l]), 64'(lk[l] && p >= 2));
            end
        end
    endtask

    task automatic send_mf(input logic [LANES-1:0] bsync, input logic [LANES-1:0] bhdr,
                           input logic [LANES-1:0] bstate, input logic [LANES-1:0] lk0,
                           input logic [LANES-1:0] lk1, input logic [LANES-1:0] lkp);
        for (int p = 0; p < MFL; p++)
            send_word(p, bsync, bhdr, bstate, (p == 0) ? lk0 : ((p == 1) ? lk1 : lkp));
        mf_n++;
    endtask

    // Four metaframes: lanes in 'which' lock after the fourth sync word
    task automatic relock(input logic [LANES-1:0] which, input logic [LANES-1:0] already,
                          input logic [LANES-1:0] bhdr);
        logic [LANES-1:0] lk;
        for (int m = 0; m < 4; m++) begin
            lk = (m == 3) ? (already | which) : already;
            send_mf('0, bhdr, '0, already, lk, lk);
        end
    endtask

    task automatic check_status(input string tag, input logic [LANES-1:0] exp_lock,
                                input logic [7:0] exp_e0, input logic [7:0] exp_e1);
        check_eq({tag, ".locked"}, 64'(locked), 64'(exp_lock));
        check_eq({tag, ".all_locked"}, 64'(all_locked), 64'(&exp_lock));
        check_eq({tag, ".err0"}, 64'(err[7:0]), 64'(exp_e0));
        check_eq({tag, ".err1"}, 64'(err[15:8]), 64'(exp_e1));
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, ".dout"}, 64'(dout != '0), 64'd0);
        check_eq({tag, ".hout"}, 64'(hout), 64'd0);
        check_eq({tag, ".ctrl"}, 64'(ctrl), 64'd0);
        check_eq({tag, ".valid"}, 64'(valid), 64'd0);
        check_status(tag, 2'b00, 8'd0, 8'd0);
    endtask

    // Stimulus
    initial begin
        rst       = 1'b1;
        pt_mode   = 1'b0;
        din       = '0;
        hin       = '0;
        st_flip   = '0;
        tx_scr[0] = 58'h1234_5678_9abc_def;
        tx_scr[1] = 58'h0f0f_0f0f_0f0f_0f0;
        #12;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Lane 0 sees sync with the data header and must not lock
        relock(2'b10, 2'b00, 2'b01);
        check_status("hdr", 2'b10, 8'd0, 8'd0);
        relock(2'b01, 2'b10, 2'b00);
        check_status("lock", 2'b11, 8'd0, 8'd0);
        send_mf(2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11);

        // Sync loss on lane 0
        for (int k = 0; k < 3; k++)
            send_mf(2'b01, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11);
        check_status("bad3", 2'b11, 8'd3, 8'd0);
        send_mf(2'b01, 2'b00, 2'b00, 2'b11, 2'b10, 2'b10);
        check_status("bad4", 2'b10, 8'd4, 8'd0);
        relock(2'b01, 2'b10, 2'b00);

        // Scrambler-state mismatches on lane 0
        send_mf(2'b00, 2'b00, 2'b01, 2'b11, 2'b11, 2'b11);
        send_mf(2'b00, 2'b00, 2'b01, 2'b11, 2'b11, 2'b11);
        send_mf(2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11);
        check_status("mm2", 2'b11, 8'd6, 8'd0);
        send_mf(2'b00, 2'b00, 2'b01, 2'b11, 2'b11, 2'b11);
        send_mf(2'b00, 2'b00, 2'b01, 2'b11, 2'b11, 2'b11);
        send_mf(2'b00, 2'b00, 2'b01, 2'b11, 2'b11, 2'b10);
        check_status("mm3", 2'b10, 8'd9, 8'd0);
        relock(2'b01, 2'b10, 2'b00);

        // Passthrough while locked
        send_word(0, 2'b00, 2'b00, 2'b00, 2'b11);
        send_word(1, 2'b00, 2'b00, 2'b00, 2'b11);
        send_word(2, 2'b00, 2'b00, 2'b00, 2'b11);
        pt_mode = 1'b1;
        send_word(3, 2'b00, 2'b00, 2'b00, 2'b00);
        check_status("pt_first", 2'b00, 8'd9, 8'd0);
        for (int p = 4; p < MFL; p++)
            send_word(p, 2'b00, 2'b00, 2'b00, 2'b00);
        mf_n++;
        send_mf(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        check_status("pt_hold", 2'b00, 8'd9, 8'd0);
        pt_mode = 1'b0;
        relock(2'b11, 2'b00, 2'b00);
        check_status("pt_relock", 2'b11, 8'd9, 8'd0);

        // Asynchronous reset mid-payload
        for (int p = 0; p < 4; p++)
            send_word(p, 2'b00, 2'b00, 2'b00, 2'b11);
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        @(negedge clk);
        rst = 1'b0;
        mf_n++;
        relock(2'b11, 2'b00, 2'b00);
        check_status("rst_relock", 2'b11, 8'd0, 8'd0);

        // Saturation: 300 bad syncs on lane 0 with relocks in between
        chk_words = 1'b0;
        for (int r = 0; r < 75; r++) begin
            for (int k = 0; k < 4; k++)
                send_mf(2'b01, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11);
            relock(2'b01, 2'b10, 2'b00);
            if (r == 62)
                check_status("sat252", 2'b11, 8'd252, 8'd0);
        end
        chk_words = 1'b1;
        check_status("sat", 2'b11, 8'd255, 8'd0);
        send_mf(2'b00, 2'b00, 2'b00, 2'b11, 2'b11, 2'b11);
        check_status("final", 2'b11, 8'd255, 8'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/interlaken_mlane_descrambler.md
# interlaken_mlane_descrambler

Multi-lane, parametrised Interlaken receive descrambler/framer. One independent lane engine per GT lane performs metaframe sync hunt, verify and lock on each 64b/67b stream, then self-synchronously descrambles payload words with x^58+x^39+1. It sits between the GT RX gearbox outputs and the lane deskew/CRC stage. Over a single-lane descrambler it adds a lane count, lock/unlock thresholds, metaframe length, header checking, per-word control/valid flags and saturating error counters.

## Interface
- LANES, 4, number of independent lanes (1..24)
- RX_DATA_WIDTH, 64, word width per lane; only 64 is supported
- SYNC_WORD, 64'h78f678f678f678f6, Interlaken sync word
- META_FRAME_LEN, 16, words per metaframe, including sync and scrambler-state words (range 4..8192)
- SYNC_GOOD, 4, consecutive good sync words needed to lock
- SYNC_BAD, 4, consecutive bad sync words that cause loss of lock
- MISMATCH_MAX, 3, consecutive scrambler-state mismatches that cause loss of lock
- USER_CLK  in  1  single clock; all logic on its rising edge
- SYSTEM_RESET  in  1  asynchronous, active-high reset
- PASSTHROUGH  in  1  forces all lanes to HUNT and raw pass-through
- SCRAMBLED_DATA_IN  in  LANES*64  lane n at bits [64n+63:64n]
- HEADER_IN  in  LANES*2  67b framing header per lane
- UNSCRAMBLED_DATA_OUT  out  LANES*64  descrambled or raw data
- HEADER_OUT  out  LANES*2  HEADER_IN delayed by one cycle
- CTRL_OUT  out  LANES  word is a sync or scrambler-state word (locked only)
- VALID_OUT  out  LANES  word is a descrambled payload word
- LOCKED  out  LANES  per-lane lock status
- ALL_LOCKED  out  1  AND of LOCKED
- ERR_CNT  out  LANES*8  per-lane saturating error counter

## Operation
- Per lane:
  - Word position counter pos, range 0..META_FRAME_LEN-1; pos 0 is sync, pos 1 is scrambler state, the rest are payload.
  - sync_ok = (data == SYNC_WORD) && (header == 2'b10).
- HUNT:
  - Output data is raw; CTRL/VALID/LOCKED are 0.
  - On sync_ok: pos ← 1, good_ctr ← 1, go to VERIFY.
- VERIFY:
  - pos advances every word and wraps to 0.
  - At pos 0: if sync_ok, good_ctr++; when good_ctr reaches SYNC_GOOD, go to LOCKED with bad_ctr = mm_ctr = 0 and first_state = 1.
  - At pos 0 without sync_ok: go to HUNT.
  - Outputs are as in HUNT.
- LOCKED (LOCKED = 1):
  - pos 0:
    - Raw output, CTRL = 1.
    - If sync_ok, bad_ctr ← 0.
    - Otherwise bad_ctr++ and ERR_CNT++. When bad_ctr reaches SYNC_BAD, go to HUNT.
  - pos 1:
    - Output raw, CTRL = 1.
    - If first_state is set: load state ← data[57:0], clear first_state; no compare.
    - Else if running state == data[57:0]: mm_ctr ← 0.
    - Else: state ← data[57:0], mm_ctr++, ERR_CNT++. When mm_ctr reaches MISMATCH_MAX, go to HUNT.
  - pos ≥ 2:
    - VALID = 1, output is descrambled.
    - Bits processed LSB first, per bit i: out[i] = in[i] ^ s[38] ^ s[57], then s ← {s[56:0], in[i]}.
    - State is advanced by 64 bits per word; it is not advanced on pos 0 or pos 1.
- Transition to HUNT from any state: counters clear, state ← all ones, first_state ← 1.
- PASSTHROUGH = 1: lane is held in HUNT with raw output; ERR_CNT holds its value.
- ERR_CNT saturates at 255 and is cleared only by reset.
- Lanes are fully independent. ALL_LOCKED is combinational from the LOCKED registers.

## Timing
- Latency: 1 cycle from data/header input to every data output (UNSCRAMBLED_DATA_OUT, HEADER_OUT, CTRL_OUT, VALID_OUT).
- Every input word is consumed each cycle; there is no backpressure and no gaps.
- LOCKED is registered with the state. It rises on the cycle after the SYNC_GOOD-th sync word. It falls on the cycle after the word that trips the SYNC_BAD or MISMATCH_MAX threshold.
- Flags on a word that causes unlock still reflect the LOCKED treatment of that word.
- Reset values:
  - All outputs 0.
  - State HUNT; pos 0; all counters 0.
  - Scrambler state all ones; first_state 1.
- Reset is honoured asynchronously at any time, including mid-metaframe.
- PASSTHROUGH is sampled synchronously and takes effect on the next edge.
- Simultaneous events at pos 0: a bad-sync unlock takes priority; the lane moves to HUNT and does not re-hunt on that same word.

## Structure
- Shared package interlaken_pkg holds:
  - the SYNC_WORD default;
  - the polynomial tap constants (38, 57);
  - the header codes (2'b10 control, 2'b01 data);
  - the lane state enum (HUNT, VERIFY, LOCKED).
- Sub-module interlaken_descrambler_lane: a single-lane engine that owns its state machine, counters, descramble function and output registers. The top level generates LANES instances, slices the buses and computes ALL_LOCKED.

## Test plan
- **Clean lock.** LANES=2, META_FRAME_LEN=16. Drive valid metaframes with header 10 on sync words and correct state words. Required: LOCKED rises 1 cycle after the 4th sync word; payload VALID=1 and output equals the original plaintext; ERR_CNT=0.
- **Sync loss.** Lane 0 locked; corrupt 4 consecutive sync words. Required: LOCKED[0] falls after the 4th bad sync; ERR_CNT[0]=4; lane 1 stays locked.
- **State mismatch.** Corrupt 2 state words, then send correct ones. Required: still locked, mm_ctr resets, ERR_CNT=2. Corrupt 3 consecutive state words: required unlock.
- **Header check.** SYNC_WORD with header 01 during HUNT. Required: lane stays in HUNT; LOCKED=0.
- **Reset and passthrough.** Assert SYSTEM_RESET mid-payload while locked. Required: all outputs 0 immediately (asynchronous). Assert PASSTHROUGH while locked. Required: LOCKED=0 next cycle; data passes raw with 1-cycle latency.
- **Saturation.** Drive 300 bad syncs after lock, relocking repeatedly. Required: ERR_CNT holds at 255.
